// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, RV32I opcode/funct constants and operand-select types for the issue stage
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRA  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_BEQ  = 4'ha;
    localparam logic [3:0] ALU_BNE  = 4'hb;
    localparam logic [3:0] ALU_BGE  = 4'hc;
    localparam logic [3:0] ALU_BGEU = 4'hd;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
    typedef enum logic [2:0] {OP2_RS2, OP2_IMM_I, OP2_IMM_S, OP2_IMM_U, OP2_SHAMT, OP2_FOUR, OP2_ZERO} op2_sel_t;

    // Shared R/I arithmetic table; alt selects SUB/SRA variants
    function automatic logic [3:0] alu_f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD:  alu_f3_op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_f3_op = ALU_SLL;
            F3_SLT:  alu_f3_op = ALU_SLT;
            F3_SLTU: alu_f3_op = ALU_SLTU;
            F3_XOR:  alu_f3_op = ALU_XOR;
            F3_SR:   alu_f3_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_f3_op = ALU_OR;
            default: alu_f3_op = ALU_AND;
        endcase
    endfunction

    // Branch compare table; BLT/BLTU reuse the set-less-than codes
    function automatic logic [3:0] alu_br_op(input logic [2:0] f3);
        case (f3)
            F3_BEQ:  alu_br_op = ALU_BEQ;
            F3_BNE:  alu_br_op = ALU_BNE;
            F3_BLT:  alu_br_op = ALU_SLT;
            F3_BGE:  alu_br_op = ALU_BGE;
            F3_BLTU: alu_br_op = ALU_SLTU;
            F3_BGEU: alu_br_op = ALU_BGEU;
            default: alu_br_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_ctrl_table.sv
// alu_ctrl_table: combinational opcode/f3/f7 decode into ALU control, operand selects and flags
module alu_ctrl_table
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic [3:0] alu_control,
    output op1_sel_t   op1_sel,
    output op2_sel_t   op2_sel,
    output logic       is_branch,
    output logic       rd_en,
    output logic       illegal
);

    logic alt;
    logic f7_ok;
    logic shift;

    assign alt   = f7 == F7_ALT;
    assign f7_ok = f7 == F7_BASE || alt;
    assign shift = f3 == F3_SLL || f3 == F3_SR;

    // Per-opcode decode; any illegal encoding falls back to ADD on the register operands
    always_comb begin
        alu_control = ALU_ADD;
        op1_sel     = OP1_RS1;
        op2_sel     = OP2_RS2;
        is_branch   = 1'b0;
        rd_en       = 1'b1;
        illegal     = 1'b0;
        case (opcode)
            OP_R: begin
                illegal     = !f7_ok || (alt && f3 != F3_ADD && f3 != F3_SR);
                alu_control = alu_f3_op(f3, alt);
            end
            OP_I: begin
                illegal     = shift && !(f7 == F7_BASE || (alt && f3 == F3_SR));
                alu_control = alu_f3_op(f3, alt && f3 == F3_SR);
                op2_sel     = shift ? OP2_SHAMT : OP2_IMM_I;
            end
            OP_BR: begin
                illegal     = f3 == F3_SLT || f3 == F3_SLTU;
                alu_control = alu_br_op(f3);
                is_branch   = 1'b1;
                rd_en       = 1'b0;
            end
            OP_LOAD: op2_sel = OP2_IMM_I;
            OP_STORE: begin
                op2_sel = OP2_IMM_S;
                rd_en   = 1'b0;
            end
            OP_LUI: begin
                op1_sel = OP1_ZERO;
                op2_sel = OP2_IMM_U;
            end
            OP_AUIPC: begin
                op1_sel = OP1_PC;
                op2_sel = OP2_IMM_U;
            end
            OP_JAL, OP_JALR: begin
                op1_sel = OP1_PC;
                op2_sel = OP2_FOUR;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_control = ALU_ADD;
            op1_sel     = OP1_RS1;
            op2_sel     = OP2_RS2;
            is_branch   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: RV32I decode-to-ALU issue stage with a single valid/ready entry; define ALU_ISSUE_ILLEGAL_EN to issue illegal entries flagged with zeroed operands
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic            is_branch,
    output logic [4:0]      rd,
    output logic            illegal
);

`ifdef ALU_ISSUE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic [3:0]      t_ctrl;
    op1_sel_t        t_op1;
    op2_sel_t        t_op2;
    logic            t_br;
    logic            t_rd_en;
    logic            t_ill;
    logic            kill;
    logic            load;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] n_op1;
    logic [XLEN-1:0] n_op2;
    logic [4:0]      n_rd;

    alu_ctrl_table u_table (
        .opcode      (instr[6:0]),
        .f3          (instr[14:12]),
        .f7          (instr[31:25]),
        .alu_control (t_ctrl),
        .op1_sel     (t_op1),
        .op2_sel     (t_op2),
        .is_branch   (t_br),
        .rd_en       (t_rd_en),
        .illegal     (t_ill)
    );

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

    // Flagged illegal entries are issued as a harmless ADD of zeros with no writeback
    assign kill     = ILL_EN & t_ill;
    assign in_ready = ~out_valid | out_ready;
    assign load     = in_valid & in_ready;

    // Operand muxes and destination register for the incoming instruction
    always_comb begin
        n_op1 = kill ? '0 :
                t_op1 == OP1_PC   ? pc :
                t_op1 == OP1_ZERO ? '0 : rs1_data;
        n_op2 = kill ? '0 :
                t_op2 == OP2_IMM_I ? imm_i :
                t_op2 == OP2_IMM_S ? imm_s :
                t_op2 == OP2_IMM_U ? imm_u :
                t_op2 == OP2_SHAMT ? XLEN'(instr[24:20]) :
                t_op2 == OP2_FOUR  ? XLEN'(4) :
                t_op2 == OP2_ZERO  ? '0 : rs2_data;
        n_rd  = (t_rd_en && !kill) ? instr[11:7] : 5'd0;
    end

    // Pipeline entry: flush beats load, load beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= ALU_ADD;
            op1         <= '0;
            op2         <= '0;
            is_branch   <= 1'b0;
            rd          <= 5'd0;
            illegal     <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (load)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
            if (load && !flush) begin
                alu_control <= t_ctrl;
                op1         <= n_op1;
                op2         <= n_op2;
                is_branch   <= t_br;
                rd          <= n_rd;
                illegal     <= kill;
            end
        end
    end

endmodule
